trace_stream_serializer: RTL and testbench
==========================================

# trace_stream_serializer

Downstream width converter for the trace path. It accepts the wide trace packets produced by the monitoring system's AXI-Stream master and re-emits each one as `BEATS = IN_WIDTH/OUT_WIDTH` narrow beats, most-significant word first, on an AXI-Stream master. That master feeds the DMA/FIFO. The block carries a packet counter so software can cross-check the number of packets it receives.

## Interface

Parameters:
- `IN_WIDTH`, default 1024: input packet width. Must be an integer multiple of `OUT_WIDTH`, with `BEATS >= 2`.
- `OUT_WIDTH`, default 64: output beat width.

Ports:
- `clk` (in, 1): single clock; all logic is on its rising edge.
- `rst_n` (in, 1): reset, synchronous and active-low.
- `S_AXIS_tvalid` (in, 1): input packet valid.
- `S_AXIS_tready` (out, 1): block accepts the input packet this cycle.
- `S_AXIS_tdata` (in, `IN_WIDTH`): input packet.
- `S_AXIS_tlast` (in, 1): input packet closes a stream burst.
- `M_AXIS_tvalid` (out, 1): output beat valid.
- `M_AXIS_tready` (in, 1): downstream accepts the beat.
- `M_AXIS_tdata` (out, `OUT_WIDTH`): output beat.
- `M_AXIS_tlast` (out, 1): final beat of a packet whose input `tlast` was 1.
- `busy` (out, 1): a packet is held or is partially sent.
- `pkt_count` (out, 32): number of packets fully emitted; wraps.

## Operation

- State machine with two states, IDLE and SEND.
- Internal registers:
  - `shreg` (`IN_WIDTH`): holds the packet being sent.
  - `last_q`: captured input `tlast`.
  - `beat_cnt`: width `$clog2(BEATS)`.
- **IDLE**
  - `S_AXIS_tready=1`, `M_AXIS_tvalid=0`.
  - When `S_AXIS_tvalid=1`: load `shreg<=S_AXIS_tdata`, `last_q<=S_AXIS_tlast`, `beat_cnt<=0`, then go to SEND.
- **SEND**
  - Outputs: `M_AXIS_tvalid=1`, `M_AXIS_tdata=shreg[IN_WIDTH-1 -: OUT_WIDTH]`, `M_AXIS_tlast=last_q & (beat_cnt==BEATS-1)`.
- On an output handshake (`M_AXIS_tvalid & M_AXIS_tready`) with `beat_cnt<BEATS-1`:
  - `shreg <<= OUT_WIDTH`, zero-filled.
  - `beat_cnt++`.
- On an output handshake with `beat_cnt==BEATS-1`:
  - `pkt_count++`.
  - If `S_AXIS_tvalid`, load the next packet as in IDLE and stay in SEND. This makes back-to-back packets bubble-free.
  - Otherwise go to IDLE.
- `S_AXIS_tready = (state==IDLE) | (state==SEND & beat_cnt==BEATS-1 & M_AXIS_tready)`. The combinational path from `M_AXIS_tready` to `S_AXIS_tready` is intentional.
- `busy = (state==SEND)`.
- `pkt_count` wraps from 0xFFFF_FFFF to 0 with no saturation.
- AXI rules:
  - While `M_AXIS_tvalid & ~M_AXIS_tready`, `M_AXIS_tdata` and `M_AXIS_tlast` hold stable and `beat_cnt` does not advance.
  - `M_AXIS_tvalid` never drops without a handshake.
- No packet is dropped or reordered. Backpressure propagates upstream through `S_AXIS_tready=0`.

## Timing

- Reset values:
  - `state=IDLE`, `shreg=0`, `last_q=0`, `beat_cnt=0`, `pkt_count=0`.
  - Therefore `M_AXIS_tvalid=0`, `M_AXIS_tdata=0`, `M_AXIS_tlast=0`, `busy=0`, `S_AXIS_tready=1` in the first cycle after the reset edge.
- Reset mid-packet: the remaining beats are discarded, with no `tlast` and no `pkt_count` increment. `M_AXIS_tvalid=0` from the cycle after the reset edge.
- Latency: an input accepted at edge N presents beat 0 on `M_AXIS` in the cycle following edge N.
- Sustained throughput with `M_AXIS_tready=1`: one packet per `BEATS` cycles and one beat every cycle, with no idle cycle between packets.
- Simultaneous final-beat handshake and `S_AXIS_tvalid`: the new packet loads on the same edge. `pkt_count` increments on that edge.
- `pkt_count` updates on the edge of the final-beat handshake and is visible in the next cycle.

## Test plan

Bench configuration: `IN_WIDTH=256`, `OUT_WIDTH=64`.

1. **Reset values.** Hold `rst_n=0` for 3 cycles, then release → `S_AXIS_tready=1`, `M_AXIS_tvalid=0`, `pkt_count=0`, `busy=0`.
2. **Single packet, no backpressure.** Send one packet, `tdata=0xAAAA..._BBBB..._CCCC..._DDDD...`, `tlast=1`, with `M_AXIS_tready=1` → beats `0xAAAA…`, `0xBBBB…`, `0xCCCC…`, `0xDDDD…` on 4 consecutive cycles. `tlast=1` on beat 3 only. `pkt_count=1`. `S_AXIS_tready=0` during beats 0–2.
3. **Back-to-back packets.** Drive 3 packets continuously with `tlast=0,0,1` and `M_AXIS_tready=1` → 12 contiguous valid beats, `tlast` only on beat 11, `pkt_count=3`. Input handshakes occur at cycles 0, 4 and 8.
4. **Random backpressure.** Toggle `M_AXIS_tready` randomly at 50% over 100 random packets → each beat stays stable while stalled. The reassembled stream matches the input bit-exactly. `pkt_count=100`.
5. **Reset mid-packet.** Assert reset after beat 1 of a packet → no further beats are emitted, `pkt_count` stays at its prior value, and the next packet starts at beat 0 with correct data.
6. **Counter wrap.** Force `pkt_count=0xFFFF_FFFF` through a hierarchical deposit, then complete one packet → `pkt_count=0`.

Source files
------------

// File: rtl/trace_stream_serializer.sv
// ---------------------------------------------------------------------------
// trace_stream_serializer
//
// Width converter on the trace path. Each wide trace packet accepted on the
// AXI-Stream slave is re-emitted as BEATS = IN_WIDTH/OUT_WIDTH narrow beats
// on the AXI-Stream master, most-significant word first. A wrapping packet
// counter lets software cross-check how many packets reached the DMA/FIFO.
//
// Parameters:
//   IN_WIDTH      input packet width (integer multiple of OUT_WIDTH)
//   OUT_WIDTH     output beat width (IN_WIDTH/OUT_WIDTH must be >= 2)
//
// Ports:
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   S_AXIS_*        wide packet input (tvalid/tready/tdata/tlast)
//   M_AXIS_*        narrow beat output (tvalid/tready/tdata/tlast)
//   busy            a packet is held or partially sent
//   pkt_count       packets fully emitted, wraps at 2^32
// ---------------------------------------------------------------------------
module trace_stream_serializer #(
  parameter int IN_WIDTH  = 1024,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic                 busy,
  output logic [31:0]          pkt_count
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [31:0]          pkt_count_q, pkt_count_d;

  logic                 final_beat;
  logic                 s_ready;
  logic                 load;

  // Next-state logic. The final-beat handshake may coincide with a new
  // packet load, which keeps back-to-back packets free of idle cycles;
  // the load assignments come last so they win over the shift path.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    last_d      = last_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;

    final_beat = (beat_cnt_q == LAST_BEAT);
    // M_AXIS_tready feeds S_AXIS_tready combinationally on the last beat.
    s_ready    = (state_q == IDLE) |
                 ((state_q == SEND) & final_beat & M_AXIS_tready);
    load       = S_AXIS_tvalid & s_ready;

    case (state_q)
      IDLE: begin
      end
      SEND: begin
        if (M_AXIS_tready) begin
          if (!final_beat) begin
            shreg_d    = shreg_q << OUT_WIDTH;
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end else begin
            pkt_count_d = pkt_count_q + 32'd1;
            if (!S_AXIS_tvalid) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      shreg_d    = S_AXIS_tdata;
      last_d     = S_AXIS_tlast;
      beat_cnt_d = '0;
      state_d    = SEND;
    end
  end

  // State registers; reset discards any partially sent packet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      last_q      <= 1'b0;
      beat_cnt_q  <= '0;
      pkt_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      last_q      <= last_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign S_AXIS_tready = s_ready;
  assign M_AXIS_tvalid = (state_q == SEND);
  assign M_AXIS_tdata  = shreg_q[IN_WIDTH-1 -: OUT_WIDTH];
  // Gated by SEND so tlast never lingers high while the master is idle.
  assign M_AXIS_tlast  = (state_q == SEND) & last_q & final_beat;
  assign busy          = (state_q == SEND);
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_trace_stream_serializer.sv
// ---------------------------------------------------------------------------
// tb_trace_stream_serializer
//
// Self-checking bench for trace_stream_serializer with IN_WIDTH=256,
// OUT_WIDTH=64 (four beats per packet). Expected beats are queued when a
// packet is driven and checked as the DUT hands each beat off downstream.
// ---------------------------------------------------------------------------
module tb_trace_stream_serializer;

  localparam int IN_W  = 256;
  localparam int OUT_W = 64;
  localparam int NB    = IN_W / OUT_W;

  typedef struct packed {
    logic [IN_W-1:0]         data;
    logic                    last;
    logic [NB-1:0][OUT_W-1:0] beat;
    logic                    exp_last;
  } vec_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [IN_W-1:0]   s_tdata = '0;
  logic              s_tlast = 1'b0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [OUT_W-1:0]  m_tdata;
  logic              m_tlast;
  logic              busy;
  logic [31:0]       pkt_count;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;

  beat_t exp_q[$];
  int    in_cycles[$];
  int    out_cycles[$];

  logic             rand_ready = 1'b0;
  logic             ready_level = 1'b1;
  logic             stall_valid = 1'b0;
  logic [OUT_W-1:0] stall_data = '0;
  logic             stall_last = 1'b0;

  vec_t vecs[7];

  trace_stream_serializer #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .S_AXIS_tvalid(s_tvalid),
    .S_AXIS_tready(s_tready),
    .S_AXIS_tdata (s_tdata),
    .S_AXIS_tlast (s_tlast),
    .M_AXIS_tvalid(m_tvalid),
    .M_AXIS_tready(m_tready),
    .M_AXIS_tdata (m_tdata),
    .M_AXIS_tlast (m_tlast),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Downstream ready: either a fixed level or a 50% random toggle.
  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  task automatic checkOutput(input string name, input logic [IN_W-1:0] actual,
                             input logic [IN_W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_valid = 1'b0;
    end else begin
      if (stall_valid) begin
        checkOutput("stall_tvalid", IN_W'(m_tvalid), IN_W'(1'b1));
        checkOutput("stall_tdata", IN_W'(m_tdata), IN_W'(stall_data));
        checkOutput("stall_tlast", IN_W'(m_tlast), IN_W'(stall_last));
      end
      stall_valid = m_tvalid && !m_tready;
      stall_data  = m_tdata;
      stall_last  = m_tlast;
      if (m_tvalid && m_tready) begin
        beat_t e;
        out_cycles.push_back(cycle);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", IN_W'(m_tdata), '0);
          if (m_tdata == '0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_beat: got beat, expected none");
          end
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", IN_W'(m_tdata), IN_W'(e.data));
          checkOutput("beat_last", IN_W'(m_tlast), IN_W'(e.last));
        end
      end
      if (s_tvalid && s_tready) in_cycles.push_back(cycle);
    end
  end

  // Queue the packet's expected beats, then hold it until accepted.
  // Returns just after the accepting edge with tvalid still high.
  task automatic applyStimulus(input vec_t v);
    int n;
    for (int b = 0; b < NB; b++) begin
      beat_t e;
      e.data = v.beat[b];
      e.last = v.exp_last && (b == NB - 1);
      exp_q.push_back(e);
    end
    s_tdata  = v.data;
    s_tlast  = v.last;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) failNow("input_accept");
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) failNow(name);
  endtask

  function automatic vec_t randomVec();
    vec_t v;
    for (int w = 0; w < IN_W / 32; w++) v.data[w*32 +: 32] = $urandom;
    v.last = 1'($urandom_range(0, 1));
    for (int b = 0; b < NB; b++) v.beat[b] = v.data[IN_W-1-OUT_W*b -: OUT_W];
    v.exp_last = v.last;
    return v;
  endfunction

  initial begin
    int d;

    // Directed vector table: input packet plus the beats it must produce.
    vecs[0].data = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                    64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    vecs[0].last = 1'b1;
    vecs[0].beat[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    vecs[0].beat[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    vecs[0].beat[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    vecs[0].beat[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    vecs[0].exp_last = 1'b1;

    vecs[1].data = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    vecs[1].last = 1'b0;
    vecs[1].beat[0] = 64'h0123_4567_89AB_CDEF;
    vecs[1].beat[1] = 64'hFEDC_BA98_7654_3210;
    vecs[1].beat[2] = 64'h1111_2222_3333_4444;
    vecs[1].beat[3] = 64'h5555_6666_7777_8888;
    vecs[1].exp_last = 1'b0;

    vecs[2].data = {64'h8000_0000_0000_0001, 64'h0000_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFE};
    vecs[2].last = 1'b0;
    vecs[2].beat[0] = 64'h8000_0000_0000_0001;
    vecs[2].beat[1] = 64'h0000_0000_0000_0000;
    vecs[2].beat[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[2].beat[3] = 64'h7FFF_FFFF_FFFF_FFFE;
    vecs[2].exp_last = 1'b0;

    vecs[3].data = {64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002,
                    64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0004};
    vecs[3].last = 1'b1;
    vecs[3].beat[0] = 64'hDEAD_BEEF_0000_0001;
    vecs[3].beat[1] = 64'hDEAD_BEEF_0000_0002;
    vecs[3].beat[2] = 64'hDEAD_BEEF_0000_0003;
    vecs[3].beat[3] = 64'hDEAD_BEEF_0000_0004;
    vecs[3].exp_last = 1'b1;

    vecs[4].data = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    vecs[4].last = 1'b1;
    vecs[4].beat[0] = 64'h1111_1111_1111_1111;
    vecs[4].beat[1] = 64'h2222_2222_2222_2222;
    vecs[4].beat[2] = 64'h3333_3333_3333_3333;
    vecs[4].beat[3] = 64'h4444_4444_4444_4444;
    vecs[4].exp_last = 1'b1;

    vecs[5].data = {64'hCAFE_0000_0000_00A0, 64'hCAFE_0000_0000_00A1,
                    64'hCAFE_0000_0000_00A2, 64'hCAFE_0000_0000_00A3};
    vecs[5].last = 1'b1;
    vecs[5].beat[0] = 64'hCAFE_0000_0000_00A0;
    vecs[5].beat[1] = 64'hCAFE_0000_0000_00A1;
    vecs[5].beat[2] = 64'hCAFE_0000_0000_00A2;
    vecs[5].beat[3] = 64'hCAFE_0000_0000_00A3;
    vecs[5].exp_last = 1'b1;

    vecs[6].data = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                    64'h00FF_00FF_00FF_00FF, 64'hFF00_FF00_FF00_FF00};
    vecs[6].last = 1'b0;
    vecs[6].beat[0] = 64'h0F0F_0F0F_0F0F_0F0F;
    vecs[6].beat[1] = 64'hF0F0_F0F0_F0F0_F0F0;
    vecs[6].beat[2] = 64'h00FF_00FF_00FF_00FF;
    vecs[6].beat[3] = 64'hFF00_FF00_FF00_FF00;
    vecs[6].exp_last = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_s_tready", IN_W'(s_tready), IN_W'(1'b1));
    checkOutput("reset_m_tvalid", IN_W'(m_tvalid), '0);
    checkOutput("reset_m_tdata", IN_W'(m_tdata), '0);
    checkOutput("reset_m_tlast", IN_W'(m_tlast), '0);
    checkOutput("reset_busy", IN_W'(busy), '0);
    checkOutput("reset_pkt_count", IN_W'(pkt_count), '0);

    // Single packet, no backpressure
    @(posedge clk);
    #1;
    in_cycles.delete();
    out_cycles.delete();
    applyStimulus(vecs[0]);
    s_tvalid = 1'b0;
    for (int b = 0; b < NB - 1; b++) begin
      @(negedge clk);
      checkOutput($sformatf("single_tvalid_b%0d", b), IN_W'(m_tvalid), IN_W'(1'b1));
      checkOutput($sformatf("single_s_tready_b%0d", b), IN_W'(s_tready), '0);
    end
    @(negedge clk);
    checkOutput("single_s_tready_b3", IN_W'(s_tready), IN_W'(1'b1));
    waitDrain("single_drain");
    checkOutput("single_pkt_count", IN_W'(pkt_count), IN_W'(1));
    checkOutput("single_beats", IN_W'(out_cycles.size()), IN_W'(NB));
    d = (out_cycles.size() == NB) ? out_cycles[NB-1] - out_cycles[0] : -1;
    checkOutput("single_contiguous", IN_W'(d), IN_W'(NB - 1));
    d = (out_cycles.size() > 0 && in_cycles.size() > 0) ? out_cycles[0] - in_cycles[0] : -1;
    checkOutput("single_latency", IN_W'(d), IN_W'(1));

    // Back-to-back packets, table-driven
    @(posedge clk);
    #1;
    in_cycles.delete();
    out_cycles.delete();
    for (int i = 1; i <= 3; i++) applyStimulus(vecs[i]);
    s_tvalid = 1'b0;
    waitDrain("b2b_drain");
    checkOutput("b2b_in_count", IN_W'(in_cycles.size()), IN_W'(3));
    d = (in_cycles.size() == 3) ? in_cycles[1] - in_cycles[0] : -1;
    checkOutput("b2b_in_gap1", IN_W'(d), IN_W'(4));
    d = (in_cycles.size() == 3) ? in_cycles[2] - in_cycles[0] : -1;
    checkOutput("b2b_in_gap2", IN_W'(d), IN_W'(8));
    checkOutput("b2b_beats", IN_W'(out_cycles.size()), IN_W'(12));
    d = (out_cycles.size() == 12) ? out_cycles[11] - out_cycles[0] : -1;
    checkOutput("b2b_contiguous", IN_W'(d), IN_W'(11));
    checkOutput("b2b_pkt_count", IN_W'(pkt_count), IN_W'(4));

    // Random backpressure with random upstream gaps
    @(posedge clk);
    #1;
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      applyStimulus(randomVec());
    end
    s_tvalid = 1'b0;
    waitDrain("random_drain");
    rand_ready = 1'b0;
    checkOutput("random_pkt_count", IN_W'(pkt_count), IN_W'(104));
    checkOutput("random_queue_empty", IN_W'(exp_q.size()), '0);

    // Reset mid-packet: start from a fresh counter so the prior value is 0
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(vecs[4]);
    s_tvalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_m_tvalid", IN_W'(m_tvalid), '0);
    checkOutput("midrst_busy", IN_W'(busy), '0);
    checkOutput("midrst_pkt_count", IN_W'(pkt_count), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_quiet_%0d", i), IN_W'(m_tvalid), '0);
    end
    @(posedge clk);
    #1;
    applyStimulus(vecs[5]);
    s_tvalid = 1'b0;
    waitDrain("midrst_drain");
    checkOutput("midrst_next_pkt_count", IN_W'(pkt_count), IN_W'(1));

    // Counter wrap
    @(posedge clk);
    #1;
    dut.pkt_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("wrap_preset", IN_W'(pkt_count), IN_W'(32'hFFFF_FFFF));
    @(posedge clk);
    #1;
    applyStimulus(vecs[6]);
    s_tvalid = 1'b0;
    waitDrain("wrap_drain");
    checkOutput("wrap_pkt_count", IN_W'(pkt_count), '0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
